// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding,
// the bundle of per-stage register enables/flushes, and the default drain depth.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctrl_t;

  localparam int PIPE_DRAIN_CYCLES = 3;

  // Every register advancing, nothing flushed.
  localparam pipe_ctrl_t CTRL_FLOW = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                       id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                       ex_mem_en: 1'b1, mem_wb_en: 1'b1};

  // Every register holding, nothing flushed.
  localparam pipe_ctrl_t CTRL_HOLD = '0;

  // Applied while reset is held: nothing loads, front stages read as empty.
  localparam pipe_ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                        id_ex_en: 1'b0, id_ex_flush: 1'b1,
                                        ex_mem_en: 1'b0, mem_wb_en: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose destination
// is a source of the instruction in ID. Register x0 never creates a hazard.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  // Pure combinational compare, evaluated in the same cycle as the decode.
  always_comb begin
    load_use = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enable/flush for load-use stall,
// taken-branch squash, data-memory wait and halt drain.
// Optional feature macro: PIPE_PERF_CNT_EN adds stall_cycles / flush_events counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = PIPE_DRAIN_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_halt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_br_taken,
  input  logic                  mem_busy,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events,
`endif
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  halted
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  pipe_ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pipe_ctrl_t       ctrl;
  logic             load_use;
  logic             halted_d;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  // State and drain-counter registers; reset aborts any drain back to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and same-cycle stage controls, resolved in priority order.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl     = CTRL_FLOW;
    halted_d = 1'b0;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_busy) begin
            // Whole pipe frozen; hazards are re-evaluated once memory answers.
            ctrl = CTRL_HOLD;
          end else if (ex_br_taken) begin
            // Wrong-path IF and ID contents are discarded, including a halt or load-use.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into EX.
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end else if (id_halt) begin
            // Halt proceeds into EX; nothing behind it is fetched.
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_flush = 1'b1;
            state_d          = DRAIN;
            cnt_d            = CNT_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_en    = 1'b0;
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_en    = !mem_busy;
          ctrl.id_ex_flush = 1'b1;
          ctrl.ex_mem_en   = !mem_busy;
          ctrl.mem_wb_en   = !mem_busy;
          if (!mem_busy) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = HALTED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        HALTED: begin
          ctrl     = CTRL_HOLD;
          halted_d = 1'b1;
        end
        default: begin
          ctrl    = CTRL_HOLD;
          state_d = RUN;
        end
      endcase
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign halted      = halted_d;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  // Saturating event counts, only meaningful while the pipe is running.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q == RUN) begin
      if ((mem_busy || load_use) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
      if (!mem_busy && ex_br_taken && (flush_q != 32'hFFFF_FFFF)) flush_d = flush_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of single-cycle RUN vectors plus
// hand-written multi-cycle sequences (stall, memory wait, halt drain, reset).
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // Packed order: pc_en if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en mem_wb_en
  localparam logic [6:0] E_DEF   = 7'b1101011;
  localparam logic [6:0] E_HOLD  = 7'b0000000;
  localparam logic [6:0] E_RST   = 7'b0010100;
  localparam logic [6:0] E_LU    = 7'b0001111;
  localparam logic [6:0] E_BR    = 7'b1111111;
  localparam logic [6:0] E_HALT  = 7'b0111011;
  localparam logic [6:0] E_DRN   = 7'b0011111;
  localparam logic [6:0] E_DRNB  = 7'b0010100;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_halt, ex_memread, ex_br_taken, mem_busy;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       memread, br, busy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [10];

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_halt     (id_halt),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .ex_br_taken (ex_br_taken),
    .mem_busy    (mem_busy),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(stall_cycles),
    .flush_events(flush_events),
`endif
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_en    (id_ex_en),
    .id_ex_flush (id_ex_flush),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [6:0] exp, input logic exp_h);
    logic [6:0] act;
    act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
    checks++;
    if (act !== exp || halted !== exp_h) begin
      errors++;
      $display("FAIL %s: ctrl=%b halted=%b, expected ctrl=%b halted=%b", nm, act, halted, exp, exp_h);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic halt,
                        input logic mr, input logic [4:0] rd, input logic br, input logic busy);
    id_rs1 = rs1; id_rs2 = rs2; id_halt = halt;
    ex_memread = mr; ex_rd = rd; ex_br_taken = br; mem_busy = busy;
  endtask

  // Inputs change 1 time unit after the rising edge, checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"idle",        5'd1,  5'd2,  5'd1,  1'b0, 1'b0, 1'b0, E_DEF};
    vecs[1] = '{"lu_rs1",      5'd7,  5'd3,  5'd7,  1'b1, 1'b0, 1'b0, E_LU};
    vecs[2] = '{"lu_rs2",      5'd4,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, E_LU};
    vecs[3] = '{"rd0_no_haz",  5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, E_DEF};
    vecs[4] = '{"no_match",    5'd6,  5'd8,  5'd9,  1'b1, 1'b0, 1'b0, E_DEF};
    vecs[5] = '{"branch",      5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, E_BR};
    vecs[6] = '{"branch_lu",   5'd5,  5'd1,  5'd5,  1'b1, 1'b1, 1'b0, E_BR};
    vecs[7] = '{"busy",        5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, E_HOLD};
    vecs[8] = '{"busy_br_lu",  5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b1, E_HOLD};
    vecs[9] = '{"lu_rd31",     5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, E_LU};

    // Reset state
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_hold", E_RST, 1'b0);
    next_cycle();
    reset = 1'b0;

    // Single-cycle decisions in RUN
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].rs1, vecs[i].rs2, 1'b0, vecs[i].memread, vecs[i].rd, vecs[i].br, vecs[i].busy);
      @(negedge clk);
      chk(vecs[i].name, vecs[i].exp, 1'b0);
      next_cycle();
    end

    // One bubble, then defaults once the load has moved on
    set_in(0, 5, 0, 1, 5, 0, 0);
    @(negedge clk); chk("seq1_stall", E_LU, 1'b0);
    next_cycle();
    set_in(0, 5, 0, 0, 0, 0, 0);
    @(negedge clk); chk("seq1_after", E_DEF, 1'b0);
    next_cycle();

    // Memory wait over a load-use: frozen 4 cycles, bubble on the 5th
    for (int c = 0; c < 4; c++) begin
      set_in(5, 0, 0, 1, 5, 0, 1);
      @(negedge clk); chk($sformatf("seq4_busy%0d", c), E_HOLD, 1'b0);
      next_cycle();
    end
    set_in(5, 0, 0, 1, 5, 0, 0);
    @(negedge clk); chk("seq4_bubble", E_LU, 1'b0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("seq4_after", E_DEF, 1'b0);
    next_cycle();

    // Halt with memory ready: 3 drain cycles, halted on the 4th
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk); chk("seq5_halt_id", E_HALT, 1'b0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk($sformatf("seq5_drain%0d", c), E_DRN, 1'b0);
      next_cycle();
    end
    @(negedge clk); chk("seq5_halted", E_HOLD, 1'b1);
    next_cycle();
    set_in(3, 3, 1, 1, 3, 1, 0);
    @(negedge clk); chk("seq5_halted_sticky", E_HOLD, 1'b1);
    next_cycle();

    // Halt with memory busy for the first 2 drain cycles: halted 2 cycles later
    do_reset();
    set_in(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk); chk("seq5b_halt_id", E_HALT, 1'b0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); chk($sformatf("seq5b_drain_busy%0d", c), E_DRNB, 1'b0);
      next_cycle();
    end
    mem_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk($sformatf("seq5b_drain%0d", c), E_DRN, 1'b0);
      next_cycle();
    end
    @(negedge clk); chk("seq5b_halted", E_HOLD, 1'b1);
    next_cycle();

    // Halt squashed by a taken branch stays in RUN
    do_reset();
    set_in(0, 0, 1, 0, 0, 1, 0);
    @(negedge clk); chk("br_squash_halt", E_BR, 1'b0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("br_squash_run", E_DEF, 1'b0);
    next_cycle();

    // Reset pulse mid-drain (cnt=2)
    set_in(0, 0, 1, 0, 0, 0, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk); chk("seq6_in_reset", E_RST, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk); chk("seq6_after", E_DEF, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    chk32("seq6_stall_cnt", stall_cycles, 32'd0);
    chk32("seq6_flush_cnt", flush_events, 32'd0);
    next_cycle();
    // load-use, busy, branch, busy+branch: 3 stall cycles, 1 flush
    set_in(4, 0, 0, 1, 4, 0, 0); next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 1); next_cycle();
    set_in(0, 0, 0, 0, 0, 1, 0); next_cycle();
    set_in(0, 0, 0, 0, 0, 1, 1); next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk32("perf_stall_cnt", stall_cycles, 32'd3);
    chk32("perf_flush_cnt", flush_events, 32'd1);
`endif
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
